// File: rtl/full_adder_if.sv
// rtl/full_adder_if.sv - operand/result bundle for the ripple-carry adder
interface full_adder_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             en;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic             Ovf;
  logic [WIDTH-1:0] Sum_q;
  logic             Cout_q;
  logic             Ovf_q;

  modport master (
    output A, B, Cin, en,
    input  Sum, Cout, Ovf, Sum_q, Cout_q, Ovf_q
  );

  modport slave (
    input  A, B, Cin, en,
    output Sum, Cout, Ovf, Sum_q, Cout_q, Ovf_q
  );
endinterface

// File: rtl/full_adder.sv
// rtl/full_adder.sv - ripple-carry adder of 1-bit cells with registered result copy
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module full_adder #(
  parameter int WIDTH = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  full_adder_if.slave   bus
);
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  // Each stage owns its carry-in/out so the chain is made of distinct nets.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic ci;
    logic co;
    if (i == 0) begin : g_first
      assign ci = bus.Cin;
    end else begin : g_next
      assign ci = g_cell[i-1].co;
    end
    fa_cell u_cell (
      .a  (bus.A[i]),
      .b  (bus.B[i]),
      .ci (ci),
      .s  (s[i]),
      .co (co)
    );
  end

  assign cout     = g_cell[WIDTH-1].co;
  assign ovf      = g_cell[WIDTH-1].co ^ g_cell[WIDTH-1].ci;
  assign bus.Sum  = s;
  assign bus.Cout = cout;
  assign bus.Ovf  = ovf;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.Sum_q  <= '0;
      bus.Cout_q <= 1'b0;
      bus.Ovf_q  <= 1'b0;
    end else if (bus.en) begin
      bus.Sum_q  <= s;
      bus.Cout_q <= cout;
      bus.Ovf_q  <= ovf;
    end
  end
endmodule

// File: tb/tb_full_adder.sv
// tb/tb_full_adder.sv - scoreboard bench for full_adder at widths 1, 8, 16 and 64
module tb_full_adder;
  logic clk;
  logic rst_n;
  bit   clk_run = 0;

  full_adder_if #(.WIDTH(1))  f1 ();
  full_adder_if #(.WIDTH(8))  f8 ();
  full_adder_if #(.WIDTH(16)) f16 ();
  full_adder_if #(.WIDTH(64)) f64 ();

  full_adder #(.WIDTH(1))  u_w1  (.clk(clk), .rst_n(rst_n), .bus(f1));
  full_adder #(.WIDTH(8))  u_w8  (.clk(clk), .rst_n(rst_n), .bus(f8));
  full_adder #(.WIDTH(16)) u_w16 (.clk(clk), .rst_n(rst_n), .bus(f16));
  full_adder #(.WIDTH(64)) u_w64 (.clk(clk), .rst_n(rst_n), .bus(f64));

  typedef struct {
    int          id;
    bit          isreg;
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    string       name;
  } exp_t;

  exp_t q[$];
  event obs;
  int   checks = 0;
  int   failures = 0;

  logic [63:0] m8_s, m16_s;
  logic        m8_c, m8_o, m16_c, m16_o;

  initial begin
    clk = 1'b0;
    wait (clk_run);
    forever #5 clk = ~clk;
  end

  // Reference: exact integer sum, and signed overflow as "true signed result out of range".
  function automatic void model(input int w, input logic [63:0] a_in, input logic [63:0] b_in,
                                input logic cin, output logic [63:0] s, output logic co,
                                output logic ov);
    logic [63:0]        mask, a, b, t;
    logic [64:0]        full, tf;
    logic signed [66:0] sa, sb, ss, lim;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    a = a_in & mask;
    b = b_in & mask;
    full = {1'b0, a} + {1'b0, b} + {64'd0, cin};
    s = full[63:0] & mask;
    tf = full >> w;
    co = tf[0];
    sa = $signed({3'b000, a});
    t = a >> (w - 1);
    if (t[0]) sa = sa - (67'sd1 <<< w);
    sb = $signed({3'b000, b});
    t = b >> (w - 1);
    if (t[0]) sb = sb - (67'sd1 <<< w);
    ss = sa + sb + $signed({66'd0, cin});
    lim = 67'sd1 <<< (w - 1);
    ov = (ss >= lim) || (ss < -lim);
  endfunction

  function automatic void get_act(input int id, input bit isreg, output logic [63:0] s,
                                  output logic co, output logic ov);
    s = 'x; co = 1'bx; ov = 1'bx;
    case (id)
      1:  begin s = isreg ? 64'(f1.Sum_q)  : 64'(f1.Sum);  co = isreg ? f1.Cout_q  : f1.Cout;  ov = isreg ? f1.Ovf_q  : f1.Ovf;  end
      8:  begin s = isreg ? 64'(f8.Sum_q)  : 64'(f8.Sum);  co = isreg ? f8.Cout_q  : f8.Cout;  ov = isreg ? f8.Ovf_q  : f8.Ovf;  end
      16: begin s = isreg ? 64'(f16.Sum_q) : 64'(f16.Sum); co = isreg ? f16.Cout_q : f16.Cout; ov = isreg ? f16.Ovf_q : f16.Ovf; end
      default: begin s = isreg ? f64.Sum_q : f64.Sum;      co = isreg ? f64.Cout_q : f64.Cout; ov = isreg ? f64.Ovf_q : f64.Ovf; end
    endcase
  endfunction

  // Monitor: drains every expectation queued before the observation point.
  initial begin
    exp_t        e;
    logic [63:0] as;
    logic        ac, ao;
    forever begin
      @(obs);
      while (q.size() > 0) begin
        e = q.pop_front();
        get_act(e.id, e.isreg, as, ac, ao);
        checks++;
        if (as !== e.sum || ac !== e.cout || ao !== e.ovf) begin
          failures++;
          $display("FAIL %s w%0d reg=%0d got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                   e.name, e.id, e.isreg, as, ac, ao, e.sum, e.cout, e.ovf);
        end
      end
    end
  end

  task automatic push(input int id, input bit isreg, input logic [63:0] s, input logic co,
                      input logic ov, input string nm);
    exp_t e;
    e.id = id; e.isreg = isreg; e.sum = s; e.cout = co; e.ovf = ov; e.name = nm;
    q.push_back(e);
  endtask

  task automatic observe();
    #1;
    -> obs;
    #1;
  endtask

  task automatic comb_chk(input int id, input string nm);
    logic [63:0] s;
    logic        co, ov;
    case (id)
      8:       model(8, 64'(f8.A), 64'(f8.B), f8.Cin, s, co, ov);
      default: model(16, 64'(f16.A), 64'(f16.B), f16.Cin, s, co, ov);
    endcase
    push(id, 1'b0, s, co, ov, nm);
    observe();
  endtask

  task automatic reg_step(input string nm);
    logic [63:0] s;
    logic        co, ov;
    @(posedge clk);
    if (!rst_n) begin
      m8_s = '0; m8_c = 0; m8_o = 0; m16_s = '0; m16_c = 0; m16_o = 0;
    end else begin
      if (f8.en) begin
        model(8, 64'(f8.A), 64'(f8.B), f8.Cin, s, co, ov);
        m8_s = s; m8_c = co; m8_o = ov;
      end
      if (f16.en) begin
        model(16, 64'(f16.A), 64'(f16.B), f16.Cin, s, co, ov);
        m16_s = s; m16_c = co; m16_o = ov;
      end
    end
    #1;
    push(8, 1'b1, m8_s, m8_c, m8_o, nm);
    push(16, 1'b1, m16_s, m16_c, m16_o, nm);
    -> obs;
    #1;
  endtask

  initial begin
    logic [1:0]  tt [8];
    logic [63:0] s;
    logic        co, ov;
    tt = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    f1.en = 0; f8.en = 0; f16.en = 0; f64.en = 0;
    f1.A = 0; f1.B = 0; f1.Cin = 0;
    f8.A = 0; f8.B = 0; f8.Cin = 0;
    f16.A = 0; f16.B = 0; f16.Cin = 0;
    f64.A = 0; f64.B = 0; f64.Cin = 0;

    // Width-1 truth table with the clock stopped and reset never driven.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      f1.A = v[2]; f1.B = v[1]; f1.Cin = v[0];
      model(1, 64'(v[2]), 64'(v[1]), v[0], s, co, ov);
      push(1, 1'b0, 64'(tt[i][0]), tt[i][1], ov, $sformatf("tt%0d", i));
      observe();
    end

    f64.A = 64'hFFFF_FFFF_FFFF_FFFF; f64.B = 64'd0; f64.Cin = 1'b1;
    push(64, 1'b0, 64'd0, 1'b1, 1'b0, "ripple64");
    observe();
    f64.A = 64'h7FFF_FFFF_FFFF_FFFF; f64.B = 64'd1; f64.Cin = 1'b0;
    push(64, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, "ovf64");
    observe();

    f8.A = 8'd5; f8.B = 8'hFC; f8.Cin = 1'b1;
    push(8, 1'b0, 64'd2, 1'b1, 1'b0, "sub5m3");
    observe();
    f8.A = 8'd3; f8.B = 8'hFA; f8.Cin = 1'b1;
    push(8, 1'b0, 64'hFE, 1'b0, 1'b0, "sub3m5");
    observe();

    // Result register sequence on width 8 (width 16 shares the reset).
    rst_n = 1'b0; f8.en = 1'b1; f16.en = 1'b1;
    clk_run = 1;
    reg_step("reset");
    rst_n = 1'b1; f8.A = 8'h80; f8.B = 8'h80; f8.Cin = 1'b0; f8.en = 1'b1; f16.en = 1'b0;
    push(8, 1'b0, 64'd0, 1'b1, 1'b1, "c80p80");
    observe();
    reg_step("cap80");
    push(8, 1'b1, 64'd0, 1'b1, 1'b1, "cap80_const");
    observe();
    f8.A = 8'h12; f8.B = 8'h34; f8.Cin = 1'b1; f8.en = 1'b0;
    comb_chk(8, "hold_comb");
    reg_step("hold");
    push(8, 1'b1, 64'd0, 1'b1, 1'b1, "hold_const");
    observe();
    rst_n = 1'b0; f8.en = 1'b1;
    reg_step("midreset");
    comb_chk(8, "midreset_comb");
    rst_n = 1'b1;

    // Randomised width-16 traffic, including enable gaps and occasional resets.
    for (int n = 0; n < 1000; n++) begin
      case ($urandom_range(0, 9))
        0:       f16.A = 16'hFFFF;
        1:       f16.A = 16'h7FFF;
        2:       f16.A = 16'h8000;
        default: f16.A = 16'($urandom_range(0, 65535));
      endcase
      f16.B   = 16'($urandom_range(0, 65535));
      f16.Cin = 1'($urandom_range(0, 1));
      f16.en  = ($urandom_range(0, 3) != 0);
      f8.A    = 8'($urandom_range(0, 255));
      f8.B    = 8'($urandom_range(0, 255));
      f8.Cin  = 1'($urandom_range(0, 1));
      f8.en   = 1'($urandom_range(0, 1));
      rst_n   = ($urandom_range(0, 39) != 0);
      comb_chk(16, "rand16");
      reg_step("rand_reg");
    end

    #5;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
